// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit controller.
package uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_e;

  localparam int FRAME_BITS_NP = 10;
  localparam int FRAME_BITS_P  = 11;
  localparam int BITCNT_W      = 4;
  localparam logic IDLE_LVL    = 1'b1;

endpackage

// File: rtl/baud_tick_gen.sv
// Baud tick generator: one-cycle btu pulse every baud_k enabled cycles (0 treated as 1).
module baud_tick_gen #(
  parameter int BAUD_W = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              enable,
  input  logic [BAUD_W-1:0] baud_k,
  output logic              btu
);

  logic [BAUD_W-1:0] cnt_q;
  logic [BAUD_W-1:0] cnt_d;
  logic [BAUD_W-1:0] last_s;

  // >= keeps the counter bounded if baud_k shrinks below the current count
  always_comb begin
    last_s = (baud_k == '0) ? '0 : (baud_k - BAUD_W'(1));
    btu    = enable && (cnt_q >= last_s);
    cnt_d  = cnt_q;
    if (clear || btu) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + BAUD_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: holding register, frame shifter and bit sequencing.
// Optional parity bit enabled with macro UART_TX_PARITY_EN.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int BAUD_W = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [DATA_W-1:0] din,
  input  logic [BAUD_W-1:0] baud_k,
`ifdef UART_TX_PARITY_EN
  input  logic              pen,
  input  logic              ohel,
`endif
  output logic              tx,
  output logic              txrdy,
  output logic              busy
);

`ifdef UART_TX_PARITY_EN
  localparam int SHIFT_W = DATA_W + 3;
`else
  localparam int SHIFT_W = DATA_W + 2;
`endif

  state_e                state_q, state_d;
  logic [DATA_W-1:0]     hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic [SHIFT_W-1:0]    shift_q, shift_d;
  logic [BITCNT_W-1:0]   bitcnt_q, bitcnt_d;
  logic [BITCNT_W-1:0]   last_bit_s;
  logic                  btu_s;

`ifdef UART_TX_PARITY_EN
  // frame length is latched in LOAD so pen may change during a frame
  logic [BITCNT_W-1:0]   last_bit_q, last_bit_d;
  assign last_bit_s = last_bit_q;
`else
  assign last_bit_s = BITCNT_W'(FRAME_BITS_NP - 1);
`endif

  baud_tick_gen #(.BAUD_W(BAUD_W)) u_baud (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_q == LOAD),
    .enable (state_q == SHIFT),
    .baud_k (baud_k),
    .btu    (btu_s)
  );

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    bitcnt_d    = bitcnt_q;
`ifdef UART_TX_PARITY_EN
    last_bit_d  = last_bit_q;
`endif
    if (wr && !hold_full_q) begin
      hold_d      = din;
      hold_full_d = 1'b1;
    end else begin
      hold_d      = hold_q;
    end
    case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
`ifdef UART_TX_PARITY_EN
        shift_d    = {1'b1, (pen ? ((^hold_q) ^ ohel) : 1'b1), hold_q, 1'b0};
        last_bit_d = pen ? BITCNT_W'(FRAME_BITS_P - 1) : BITCNT_W'(FRAME_BITS_NP - 1);
`else
        shift_d    = {1'b1, hold_q, 1'b0};
`endif
        hold_full_d = 1'b0;
        bitcnt_d    = '0;
        state_d     = SHIFT;
      end
      SHIFT: begin
        if (btu_s) begin
          shift_d  = {1'b1, shift_q[SHIFT_W-1:1]};
          bitcnt_d = bitcnt_q + BITCNT_W'(1);
          if (bitcnt_q == last_bit_s) begin
            state_d = hold_full_q ? LOAD : IDLE;
          end else begin
            state_d = SHIFT;
          end
        end else begin
          state_d = SHIFT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '1;
      bitcnt_q    <= '0;
`ifdef UART_TX_PARITY_EN
      last_bit_q  <= BITCNT_W'(FRAME_BITS_NP - 1);
`endif
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      bitcnt_q    <= bitcnt_d;
`ifdef UART_TX_PARITY_EN
      last_bit_q  <= last_bit_d;
`endif
    end
  end

  assign tx    = (state_q == SHIFT) ? shift_q[0] : IDLE_LVL;
  assign txrdy = ~hold_full_q;
  assign busy  = (state_q == LOAD) || (state_q == SHIFT);

endmodule
